restador_borrowlook_serie: RTL and testbench
============================================

Name: restador_borrowlook_serie

Overview:
- Multi-cycle unsigned/two's-complement subtractor. Computes D = A - B - Bi over WIDTH bits, 4 bits per clock.
- Each cycle uses one 4-bit borrow-lookahead slice. A registered borrow carries between slices.
- Inverse-direction companion to the team's 4-bit carry-lookahead adder. It reuses the same propagate/generate structure on A and ~B.
- Sits behind a valid/ready handshake on both sides, for use in datapaths that cannot afford a full-width lookahead tree.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of 4-bit slices (derived localparam, not user-set).

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bi  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- D  output  WIDTH  difference, A - B - Bi mod 2^WIDTH
- Bo  output  1  borrow-out; 1 iff A < B + Bi (unsigned)

Behaviour:
- Reset:
  - rst is asynchronous and active-high.
  - Asserting rst forces state IDLE, in_ready=1, out_valid=0, D=0, Bo=0, slice counter=0, borrow register=0.
  - Reset mid-operation abandons the transaction; no output is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: latch A, B and borrow register <= Bi; counter <= 0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, slice k=counter takes A[4k+3:4k], ~B[4k+3:4k] and carry-in = ~borrow.
  - It computes P = a^~b, G = a&~b, lookahead carries, sum, and carry-out. Borrow = ~carry-out.
  - D[4k+3:4k] <= slice sum; borrow register <= ~carry-out; counter++.
  - At counter = NSLICE-1: Bo <= final borrow; go to DONE.
  - CALC lasts exactly NSLICE cycles.
- DONE:
  - out_valid=1. D and Bo are held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - in_ready remains 0 in DONE. No overlap: the next accept occurs at the earliest in the cycle after the IDLE entry.
- Latency: accept edge to out_valid high is NSLICE cycles (4 for WIDTH=16). Throughput is one op per NSLICE+2 cycles with out_ready tied high.
- Arithmetic:
  - Borrow does not truncate between slices.
  - Bi=1 with A=B gives D=all ones and Bo=1.
  - Inputs are sampled only at the accept edge. Changes to A/B/Bi afterwards have no effect.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; no queueing.

Optional Feature:
- Macro: RESTADOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, valid with out_valid.
  - ovf = signed overflow = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), using the latched operands.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include file:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Slice width constant SLICE_W=4.
- One sub-module, restador_borrowlook_4bits, which is purely combinational:
  - Inputs a[3:0], b[3:0], bi.
  - Outputs d[3:0], bo.
  - Internally uses P/G of a and ~b with a 4-bit lookahead network.
- The top level holds the FSM, counter, operand/result registers and borrow register, and instantiates one slice.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0234, Bi=0, out_ready=1 -> out_valid rises 4 cycles after accept; D=0x1000, Bo=0.
- A=0x0000, B=0x0001, Bi=0 -> D=0xFFFF, Bo=1; with RESTADOR_OVF_EN, ovf=0.
- A=0x1000, B=0x0001, Bi=0 -> D=0x0FFF, Bo=0 (borrow ripples through three slices). Also A=0x5555, B=0x5555, Bi=1 -> D=0xFFFF, Bo=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> D/Bo/out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 in the next cycle.
- Assert rst during the 2nd CALC cycle -> immediately out_valid=0, D=0, in_ready=1. The next op A=0x0003, B=0x0001 -> D=0x0002.
- With RESTADOR_OVF_EN: A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, Bo=0. A=0x7FFF, B=0xFFFF -> D=0x8000, ovf=1, Bo=1.

Source files
------------

// File: rtl/restador_borrowlook_serie_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor:
// FSM state encoding and the width of one lookahead slice.
package restador_borrowlook_serie_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : restador_borrowlook_serie_pkg

// File: rtl/restador_borrowlook_4bits.sv
// 4-bit borrow-lookahead subtract slice, purely combinational.
// Computes d = a - b - bi as a + ~b + ~bi, using the same propagate/generate
// lookahead network as the 4-bit carry-lookahead adder; borrow = ~carry.
module restador_borrowlook_4bits
  import restador_borrowlook_serie_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  logic [SLICE_W-1:0] nb;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign nb = ~b;
  assign p  = a ^ nb;
  assign g  = a & nb;

  // Flat lookahead carries: each carry is a two-level sum of products of
  // P/G and the slice carry-in, with no ripple between bit positions.
  assign c[0] = ~bi;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d  = p ^ c[SLICE_W-1:0];
  assign bo = ~c[SLICE_W];

endmodule : restador_borrowlook_4bits

// File: rtl/restador_borrowlook_serie.sv
// Multi-cycle subtractor D = A - B - Bi, processed 4 bits per clock through
// one borrow-lookahead slice with a registered borrow between slices.
// Valid/ready handshake on both sides; one transaction in flight at a time.
// Optional: define RESTADOR_OVF_EN to add the signed-overflow output ovf.
module restador_borrowlook_serie
  import restador_borrowlook_serie_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bo
`ifdef RESTADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   d_q;
  logic               bo_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last;
  logic [SLICE_W-1:0] sl_d;
  logic               sl_bo;

  // The operand registers shift right one slice per CALC cycle, so the
  // single slice always reads the low nibble.
  restador_borrowlook_4bits u_slice (
    .a  (a_q[SLICE_W-1:0]),
    .b  (b_q[SLICE_W-1:0]),
    .bi (borrow_q),
    .d  (sl_d),
    .bo (sl_bo)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_W'(NSLICE - 1));
  assign D      = d_q;
  assign Bo     = bo_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef RESTADOR_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  assign ovf = ovf_q;

  // Latch operand sign bits at accept; resolve overflow with the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (state == ST_CALC && last) begin
      ovf_q <= (a_msb != b_msb) && (sl_d[SLICE_W-1] != a_msb);
    end
  end
`endif

  // Operand capture, per-slice result assembly, borrow chain and counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the result registers are reset as well, because D and Bo must
    // read zero after reset rather than a stale or unknown value.
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= Bi;
      cnt      <= '0;
    end else if (state == ST_CALC) begin
      a_q      <= a_q >> SLICE_W;
      b_q      <= b_q >> SLICE_W;
      // New slice result enters at the top; after NSLICE cycles the first
      // slice has shifted down to bit 0.
      d_q      <= (d_q >> SLICE_W) | (WIDTH'(sl_d) << (WIDTH - SLICE_W));
      borrow_q <= sl_bo;
      cnt      <= cnt + CNT_W'(1);
      if (last) bo_q <= sl_bo;
    end
  end

endmodule : restador_borrowlook_serie

// File: tb/tb_restador_borrowlook_serie.sv
// Directed testbench for restador_borrowlook_serie (WIDTH=16).
// Covers reset, latency, arithmetic corner cases, backpressure, mid-op reset
// and, when RESTADOR_OVF_EN is defined, the signed-overflow output.
module tb_restador_borrowlook_serie;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bo;
`ifdef RESTADOR_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  restador_borrowlook_serie #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bi        (Bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bo        (Bo)
`ifdef RESTADOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Wait for in_ready, present one operand set for one accept edge, scramble
  // the inputs afterwards, then wait (bounded) for out_valid.
  task automatic do_op(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                       input logic bi_in, output logic ok, output int lat,
                       output logic [WIDTH-1:0] d_got, output logic bo_got,
                       output logic ovf_got);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    A = a_in; B = b_in; Bi = bi_in; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); Bi = ~bi_in;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    d_got  = D;
    bo_got = Bo;
`ifdef RESTADOR_OVF_EN
    ovf_got = ovf;
`else
    ovf_got = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bi = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (D !== 16'h0000 || Bo !== 1'b0) begin
      failures++; $display("FAIL reset_d_bo got=%h/%b exp=0000/0", D, Bo);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic ok; int lat; logic [WIDTH-1:0] d; logic bo; logic ov;
    do_op(16'h1234, 16'h0234, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || lat !== NSLICE) begin
      failures++; $display("FAIL basic_latency got=%0d ok=%b exp=%0d", lat, ok, NSLICE);
    end
    checks++;
    if (d !== 16'h1000 || bo !== 1'b0) begin
      failures++; $display("FAIL basic_result got=%h/%b exp=1000/0", d, bo);
    end
    // out_ready is high, so the block is back in IDLE one edge later.
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_return got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[6];
    logic ok; int lat; logic [WIDTH-1:0] d; logic bo; logic ov;
    vecs[0] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[2] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{16'hA5C3, 16'h1234, 1'b1, 16'h938E, 1'b0};
    vecs[5] = '{16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bi, ok, lat, d, bo, ov);
      checks++;
      if (!ok || d !== vecs[i].d || bo !== vecs[i].bo) begin
        failures++;
        $display("FAIL vec%0d %h-%h-%b got=%h/%b ok=%b exp=%h/%b",
                 i, vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, ok, vecs[i].d, vecs[i].bo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok; int lat; logic [WIDTH-1:0] d; logic bo; logic ov;
    int bad;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(16'h4321, 16'h1111, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || d !== 16'h3210 || bo !== 1'b0) begin
      failures++; $display("FAIL bp_result got=%h/%b ok=%b exp=3210/0", d, bo, ok);
    end
    bad = 0;
    A = 16'h0000; B = 16'h0001; Bi = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 16'h3210 || Bo !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold got %0d unstable cycles exp=0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    checks++;
    if (D !== 16'h3210) begin
      failures++; $display("FAIL bp_ignored_input got=%h exp=3210", D);
    end
  endtask

  task automatic test_reset_mid();
    logic ok; int lat; logic [WIDTH-1:0] d; logic bo; logic ov;
    A = 16'hFFFF; B = 16'h0001; Bi = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;       // accept edge
    in_valid = 1'b0;
    @(posedge clk); #1;       // now in the second CALC cycle
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || D !== 16'h0000 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midreset got out_valid=%b D=%h in_ready=%b exp 0/0000/1", out_valid, D, in_ready);
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_no_output got out_valid=%b exp=0", out_valid);
    end
    do_op(16'h0003, 16'h0001, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || d !== 16'h0002 || bo !== 1'b0) begin
      failures++; $display("FAIL midreset_next got=%h/%b ok=%b exp=0002/0", d, bo, ok);
    end
  endtask

`ifdef RESTADOR_OVF_EN
  task automatic test_ovf();
    logic ok; int lat; logic [WIDTH-1:0] d; logic bo; logic ov;
    do_op(16'h0000, 16'h0001, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || d !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
      failures++; $display("FAIL ovf_0m1 got=%h/%b/%b exp=FFFF/1/0", d, bo, ov);
    end
    do_op(16'h8000, 16'h0001, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || d !== 16'h7FFF || bo !== 1'b0 || ov !== 1'b1) begin
      failures++; $display("FAIL ovf_min got=%h/%b/%b exp=7FFF/0/1", d, bo, ov);
    end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, ok, lat, d, bo, ov);
    checks++;
    if (!ok || d !== 16'h8000 || bo !== 1'b1 || ov !== 1'b1) begin
      failures++; $display("FAIL ovf_max got=%h/%b/%b exp=8000/1/1", d, bo, ov);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
`ifdef RESTADOR_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_restador_borrowlook_serie
